// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller, byte/half stores by read-modify-write.
// Optional `LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

   state_t      r_state;
   logic        r_we;
   logic        r_unsigned;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_mdata;
   logic [31:0] r_rdata;

   logic [31:0] w_addr_al;
   logic [4:0]  w_shift;
   logic [31:0] w_rd_sh;
   logic [31:0] w_load_ext;
   logic [31:0] w_mask;
   logic [31:0] w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_fault;
   logic r_fault;
   assign w_fault   = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
   assign rsp_fault = r_fault;
`else
   assign rsp_fault = 1'b0;
`endif

   // Faulting accesses never reach memory, so aligning unconditionally is harmless.
   always_comb begin
      w_addr_al = req_addr;
      if (req_size[1])
         w_addr_al[1:0] = 2'b00;
      else if (req_size[0])
         w_addr_al[0] = 1'b0;
   end

   assign w_shift = {r_addr[1:0], 3'b000};
   assign w_rd_sh = mem_rdata >> w_shift;

   always_comb begin
      case (r_size)
         2'b00:   w_load_ext = {{24{~r_unsigned & w_rd_sh[7]}}, w_rd_sh[7:0]};
         2'b01:   w_load_ext = {{16{~r_unsigned & w_rd_sh[15]}}, w_rd_sh[15:0]};
         default: w_load_ext = mem_rdata;
      endcase
   end

   // Only byte and half stores pass through MERGE, so r_size[0] selects the lane width.
   assign w_mask  = (r_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
   assign w_merge = (mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_mdata    <= 32'h0;
         r_rdata    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_fault    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_unsigned <= req_unsigned;
                  r_size     <= req_size;
                  r_addr     <= w_addr_al;
                  r_wdata    <= req_wdata;
                  r_mdata    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (w_fault) begin
                     r_rdata <= 32'h0;
                     r_fault <= 1'b1;
                     r_state <= RESP;
                  end else
`endif
                  if (!req_we)
                     r_state <= LOAD;
                  else if (req_size[1])
                     r_state <= WRITE;
                  else
                     r_state <= MERGE;
               end
            end
            MERGE: begin
               r_mdata <= w_merge;
               r_state <= WRITE;
            end
            LOAD, WRITE: begin
               r_rdata <= r_we ? 32'h0 : w_load_ext;
`ifdef LSU_MISALIGN_TRAP_EN
               r_fault <= 1'b0;
`endif
               r_state <= RESP;
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign mem_wr_en = (r_state == WRITE) && !rst;
   assign mem_addr  = {2'b00, r_addr[31:2]};
   assign mem_wdata = (r_state == WRITE) ? r_mdata : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - table-driven scoreboard bench for lsu_ctrl with a 16-word memory model.
`timescale 1ns/1ps
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [16];
   logic        mem_clr = 1'b1;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[3:0]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      end else if (mem_wr_en) begin
         mem[mem_addr[3:0]] <= mem_wdata;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_lat;
      logic        exp_wr;
      logic [31:0] exp_widx;
      logic [31:0] exp_wword;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] word;
   } wr_t;

   rsp_t rsp_q[$];
   wr_t  wr_q[$];
   int   acc_q[$];
   int   nchk = 0;
   int   nbad = 0;
   int   cyc = 0;
   int   n_acc = 0;
   int   n_rsp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
      end
   endtask

   // Monitor: accept edges, responses with latency, and memory writes, all sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         acc_q.push_back(cyc + 1);
         n_acc++;
      end
      if (rsp_valid) begin
         n_rsp++;
         chk("rsp_expected", {31'h0, (rsp_q.size() > 0 && acc_q.size() > 0)}, 32'h1);
         if (rsp_q.size() > 0 && acc_q.size() > 0) begin
            rsp_t e;
            int   a;
            e = rsp_q.pop_front();
            a = acc_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
            chk("rsp_latency", cyc + 1 - a, e.lat);
         end
      end
      if (mem_wr_en) begin
         chk("wr_expected", {31'h0, (wr_q.size() > 0)}, 32'h1);
         if (wr_q.size() > 0) begin
            wr_t w;
            w = wr_q.pop_front();
            chk("wr_addr", mem_addr, w.idx);
            chk("wr_data", mem_wdata, w.word);
         end
      end else if (!rst) begin
         chk("wdata_idle", mem_wdata, 32'h0);
      end
   end

   function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic un,
                               input logic [31:0] ad, input logic [31:0] wd,
                               input logic [31:0] er, input logic ef, input int el,
                               input logic ew, input logic [31:0] wi, input logic [31:0] ww);
      vec_t v;
      v.we = we; v.size = sz; v.uns = un; v.addr = ad; v.wdata = wd;
      v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el;
      v.exp_wr = ew; v.exp_widx = wi; v.exp_wword = ww;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
   endtask

   task automatic push_exp(input vec_t v);
      rsp_t r;
      wr_t  w;
      r.rdata = v.exp_rdata; r.fault = v.exp_fault; r.lat = v.exp_lat;
      rsp_q.push_back(r);
      if (v.exp_wr) begin
         w.idx = v.exp_widx; w.word = v.exp_wword;
         wr_q.push_back(w);
      end
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      chk(nm, {31'h0, (k < 10)}, 32'h1);
   endtask

   task automatic send(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      push_exp(v);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_idle("idle_timeout");
   endtask

   vec_t vt[$];

   initial begin
      vec_t v;
      int   n0;

      vt.push_back(mk(1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'd2, 32'hDEADBEEF));
      vt.push_back(mk(0, 2'b10, 0, 32'h8, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(1, 2'b10, 0, 32'h4, 32'hCAFEF00D, 32'h0,        0, 2, 1, 32'd1, 32'hCAFEF00D));
      vt.push_back(mk(1, 2'b10, 0, 32'h8, 32'h11223344, 32'h0,        0, 2, 1, 32'd2, 32'h11223344));
      vt.push_back(mk(1, 2'b00, 0, 32'h9, 32'h123456AA, 32'h0,        0, 3, 1, 32'd2, 32'h1122AA44));
      vt.push_back(mk(0, 2'b00, 0, 32'h9, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b00, 1, 32'h9, 32'h0,        32'h000000AA, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b00, 0, 32'hB, 32'h0,        32'h00000011, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(1, 2'b01, 0, 32'hE, 32'hABCD8001, 32'h0,        0, 3, 1, 32'd3, 32'h80010000));
      vt.push_back(mk(0, 2'b01, 0, 32'hE, 32'h0,        32'hFFFF8001, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b01, 1, 32'hE, 32'h0,        32'h00008001, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b11, 0, 32'h8, 32'h0,        32'h1122AA44, 0, 2, 0, 32'd0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
      vt.push_back(mk(0, 2'b10, 0, 32'h5, 32'h0,        32'h0,        1, 1, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b01, 0, 32'hF, 32'h0,        32'h0,        1, 1, 0, 32'd0, 32'h0));
      vt.push_back(mk(1, 2'b10, 0, 32'h6, 32'h77777777, 32'h0,        1, 1, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b10, 0, 32'h4, 32'h0,        32'hCAFEF00D, 0, 2, 0, 32'd0, 32'h0));
`else
      vt.push_back(mk(0, 2'b10, 0, 32'h5, 32'h0,        32'hCAFEF00D, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(0, 2'b01, 0, 32'hF, 32'h0,        32'hFFFF8001, 0, 2, 0, 32'd0, 32'h0));
      vt.push_back(mk(1, 2'b10, 0, 32'h6, 32'h77777777, 32'h0,        0, 2, 1, 32'd1, 32'h77777777));
      vt.push_back(mk(0, 2'b10, 0, 32'h4, 32'h0,        32'h77777777, 0, 2, 0, 32'd0, 32'h0));
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_fault", {31'h0, rsp_fault}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_clr = 1'b0;

      for (int i = 0; i < vt.size(); i++) send(vt[i]);

      // Continuous req_valid: accepts only from IDLE, one every three cycles for loads.
      v = mk(0, 2'b10, 0, 32'h8, 32'h0, 32'h1122AA44, 0, 2, 0, 32'd0, 32'h0);
      n0 = n_acc;
      for (int i = 0; i < 4; i++) push_exp(v);
      @(posedge clk); #1;
      drive(v);
      req_valid = 1'b1;
      repeat (12) @(posedge clk);
      #1 req_valid = 1'b0;
      wait_idle("b2b_idle_timeout");
      chk("b2b_accepts", n_acc - n0, 4);
      chk("b2b_rsp_left", rsp_q.size(), 0);

      // Reset while a byte store sits in WRITE: no write may land.
      @(posedge clk); #1;
      drive(mk(1, 2'b00, 0, 32'h9, 32'h00000055, 32'h0, 0, 0, 0, 32'd0, 32'h0));
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_wr_en", {31'h0, mem_wr_en}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      acc_q.delete();
      @(negedge clk);
      chk("rstw_ready", {31'h0, req_ready}, 32'h1);
      chk("rstw_mem", mem[2], 32'h1122AA44);
      chk("rstw_rdata_clr", rsp_rdata, 32'h0);

      // Request presented together with reset must be dropped.
      n0 = n_rsp;
      @(posedge clk); #1;
      rst = 1'b1;
      drive(mk(1, 2'b10, 0, 32'h0, 32'h12345678, 32'h0, 0, 0, 0, 32'd0, 32'h0));
      req_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("rstreq_mem", mem[0], 32'h0);
      chk("rstreq_rsp", n_rsp - n0, 0);

      chk("rsp_q_empty", rsp_q.size(), 0);
      chk("wr_q_empty", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
